// File: rtl/demux2_8b_buf_pkg.sv
// rtl/demux2_8b_buf_pkg.sv - shared types and sizes for the buffered 1-to-2 byte demux
package Demux_pkg;

    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    typedef logic [7:0]       byte_t;
    typedef logic [CNT_W-1:0] count_t;

    localparam count_t FULL_COUNT  = count_t'(DEPTH);
    localparam count_t EMPTY_COUNT = '0;

endpackage

// File: rtl/demux2_8b_buf_fifo.sv
// rtl/demux2_8b_buf_fifo.sv - 2-entry byte FIFO with registered occupancy
module Fifo2_8b_RTL
    import Demux_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   enq_val,
    input  byte_t  enq_data,
    output logic   full,
    input  logic   deq_rdy,
    output logic   deq_val,
    output byte_t  deq_data,
    output count_t count
);

    byte_t  entries_q [DEPTH];
    byte_t  entries_d [DEPTH];
    logic   wr_ptr_q, wr_ptr_d;
    logic   rd_ptr_q, rd_ptr_d;
    count_t count_q, count_d;
    logic   do_enq;
    logic   do_deq;

    // Next-state: enqueue refused when full, dequeue only when non-empty; reset wins over both.
    always_comb begin
        do_enq   = enq_val && (count_q != FULL_COUNT);
        do_deq   = deq_rdy && (count_q != EMPTY_COUNT);
        entries_d = entries_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = EMPTY_COUNT;
        end else begin
            if (do_enq) begin
                entries_d[wr_ptr_q] = enq_data;
                wr_ptr_d            = ~wr_ptr_q;
            end
            if (do_deq) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + count_t'(1);
                2'b01:   count_d = count_q - count_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
        wr_ptr_q  <= wr_ptr_d;
        rd_ptr_q  <= rd_ptr_d;
        count_q   <= count_d;
    end

    assign full     = (count_q == FULL_COUNT);
    assign deq_val  = (count_q != EMPTY_COUNT);
    assign deq_data = deq_val ? entries_q[rd_ptr_q] : 8'h00;
    assign count    = count_q;

endmodule

// File: rtl/demux2_8b_buf.sv
// rtl/demux2_8b_buf.sv - steers one input byte stream into two independently buffered channels
module demux2_8b_buf
    import Demux_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       in_val,
    input  logic       sel,
    output logic       in_rdy,
    output logic [7:0] out0,
    output logic       out0_val,
    input  logic       out0_rdy,
    output logic [1:0] count0,
    output logic [7:0] out1,
    output logic       out1_val,
    input  logic       out1_rdy,
    output logic [1:0] count1
);

    logic full0;
    logic full1;
    logic enq0;
    logic enq1;

    // Ready depends only on the selected channel's registered fullness, never on consumer ready.
    always_comb begin
        in_rdy = !reset && !(sel ? full1 : full0);
        enq0   = in_val && in_rdy && !sel;
        enq1   = in_val && in_rdy &&  sel;
    end

    Fifo2_8b_RTL u_fifo0 (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (enq0),
        .enq_data (in),
        .full     (full0),
        .deq_rdy  (out0_rdy),
        .deq_val  (out0_val),
        .deq_data (out0),
        .count    (count0)
    );

    Fifo2_8b_RTL u_fifo1 (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (enq1),
        .enq_data (in),
        .full     (full1),
        .deq_rdy  (out1_rdy),
        .deq_val  (out1_val),
        .deq_data (out1),
        .count    (count1)
    );

endmodule

// File: tb/tb_demux2_8b_buf.sv
// tb/tb_demux2_8b_buf.sv - randomized and directed bench against a per-channel queue model
module tb_demux2_8b_buf;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in;
    logic       in_val;
    logic       sel;
    logic       in_rdy;
    logic [7:0] out0, out1;
    logic       out0_val, out1_val;
    logic       out0_rdy, out1_rdy;
    logic [1:0] count0, count1;

    int errors = 0;
    int checks = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] popped1[$];
    bit         capture1 = 1'b0;

    always #5 clk = ~clk;

    demux2_8b_buf dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .in_val   (in_val),
        .sel      (sel),
        .in_rdy   (in_rdy),
        .out0     (out0),
        .out0_val (out0_val),
        .out0_rdy (out0_rdy),
        .count0   (count0),
        .out1     (out1),
        .out1_val (out1_val),
        .out1_rdy (out1_rdy),
        .count1   (count1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every visible output against what the queues say it must be.
    task automatic compare_model();
        logic exp_rdy;
        exp_rdy = !reset && (sel ? (q1.size() < 2) : (q0.size() < 2));
        chk("in_rdy",   {31'd0, in_rdy},   {31'd0, exp_rdy});
        chk("out0_val", {31'd0, out0_val}, {31'd0, q0.size() != 0});
        chk("out1_val", {31'd0, out1_val}, {31'd0, q1.size() != 0});
        chk("out0",     {24'd0, out0},     {24'd0, (q0.size() != 0) ? q0[0] : 8'h00});
        chk("out1",     {24'd0, out1},     {24'd0, (q1.size() != 0) ? q1[0] : 8'h00});
        chk("count0",   {30'd0, count0},   q0.size());
        chk("count1",   {30'd0, count1},   q1.size());
    endtask

    // Apply one clock edge's worth of transfers to the queue model.
    task automatic model_edge(input logic r, input logic v, input logic s, input logic [7:0] d,
                              input logic r0, input logic r1);
        bit e0, e1, d0, d1;
        if (r) begin
            q0.delete();
            q1.delete();
            return;
        end
        e0 = v && !s && (q0.size() < 2);
        e1 = v &&  s && (q1.size() < 2);
        d0 = r0 && (q0.size() != 0);
        d1 = r1 && (q1.size() != 0);
        if (d0) void'(q0.pop_front());
        if (d1) void'(q1.pop_front());
        if (e0) q0.push_back(d);
        if (e1) q1.push_back(d);
    endtask

    // One cycle: inputs are already set after the falling edge.
    task automatic step();
        logic r, v, s, r0, r1;
        logic [7:0] d;
        #1;
        compare_model();
        if (capture1 && out1_val && out1_rdy) popped1.push_back(out1);
        r = reset; v = in_val; s = sel; d = in; r0 = out0_rdy; r1 = out1_rdy;
        @(posedge clk);
        model_edge(r, v, s, d, r0, r1);
        @(negedge clk);
    endtask

    task automatic send(input logic s, input logic [7:0] d);
        in_val = 1'b1; sel = s; in = d;
        step();
        in_val = 1'b0;
    endtask

    initial begin
        int sent;
        int budget;
        logic [31:0] seed;
        reset = 1'b1; in = 8'h00; in_val = 1'b1; sel = 1'b0; out0_rdy = 1'b0; out1_rdy = 1'b0;
        @(negedge clk);

        // Reset held with in_val high.
        step();
        step();
        #1;
        chk("lit_reset_in_rdy", {31'd0, in_rdy}, 32'd0);
        chk("lit_reset_count0", {30'd0, count0}, 32'd0);
        chk("lit_reset_out1",   {24'd0, out1},   32'd0);
        reset = 1'b0; in_val = 1'b0;
        #1;
        chk("lit_after_reset_in_rdy", {31'd0, in_rdy}, 32'd1);

        // Routing.
        out0_rdy = 1'b1; out1_rdy = 1'b1;
        send(1'b0, 8'hA5);
        #1;
        chk("lit_route_out0", {24'd0, out0}, 32'h0000_00A5);
        chk("lit_route_no_leak", {31'd0, out1_val}, 32'd0);
        send(1'b1, 8'h3C);
        #1;
        chk("lit_route_out1", {24'd0, out1}, 32'h0000_003C);
        chk("lit_route_out0_drained", {31'd0, out0_val}, 32'd0);
        step();

        // Fill and backpressure on channel 0.
        out0_rdy = 1'b0; out1_rdy = 1'b0;
        send(1'b0, 8'h11);
        send(1'b0, 8'h22);
        in_val = 1'b1; sel = 1'b0; in = 8'h33;
        #1;
        chk("lit_full_count0", {30'd0, count0}, 32'd2);
        chk("lit_full_in_rdy", {31'd0, in_rdy}, 32'd0);
        step();
        in_val = 1'b0; sel = 1'b1;
        #1;
        chk("lit_other_ch_rdy", {31'd1 & 31'd0, in_rdy}, 32'd1);
        step();
        out0_rdy = 1'b1;
        #1;
        chk("lit_drain_first", {24'd0, out0}, 32'h11);
        step();
        #1;
        chk("lit_drain_second", {24'd0, out0}, 32'h22);
        step();

        // Simultaneous enq+deq at count 1, then at count 2.
        out0_rdy = 1'b0;
        send(1'b0, 8'h44);
        out0_rdy = 1'b1;
        send(1'b0, 8'h55);
        #1;
        chk("lit_both_c1_count", {30'd0, count0}, 32'd1);
        chk("lit_both_c1_head",  {24'd0, out0},   32'h55);
        out0_rdy = 1'b0;
        send(1'b0, 8'h66);
        out0_rdy = 1'b1;
        send(1'b0, 8'h77);
        #1;
        chk("lit_c2_count", {30'd0, count0}, 32'd1);
        chk("lit_c2_head",  {24'd0, out0},   32'h66);
        step();

        // Wrap-around on channel 1 with a toggling consumer.
        capture1 = 1'b1;
        sent = 0;
        budget = 0;
        while ((popped1.size() < 10) && (budget < 100)) begin
            out1_rdy = budget[0] ? 1'b0 : 1'b1;
            in_val = (sent < 10); sel = 1'b1; in = sent[7:0];
            #1;
            if (in_val && in_rdy) sent++;
            step();
            budget++;
        end
        in_val = 1'b0;
        capture1 = 1'b0;
        chk("wrap_count", popped1.size(), 32'd10);
        for (int i = 0; i < popped1.size(); i++) begin
            chk("wrap_order", {24'd0, popped1[i]}, i);
        end

        // Reset with both channels full.
        out0_rdy = 1'b0; out1_rdy = 1'b0;
        send(1'b0, 8'hC0); send(1'b0, 8'hC1); send(1'b1, 8'hD0); send(1'b1, 8'hD1);
        #1;
        chk("lit_prefull_count1", {30'd0, count1}, 32'd2);
        reset = 1'b1; out0_rdy = 1'b1; out1_rdy = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("lit_midreset_count0", {30'd0, count0}, 32'd0);
        chk("lit_midreset_val1",   {31'd0, out1_val}, 32'd0);
        step();

        // Random run.
        seed = 32'd20240611;
        void'($urandom(seed));
        for (int c = 0; c < 200; c++) begin
            reset    = ($urandom_range(0, 49) == 0);
            in_val   = $urandom_range(0, 3) != 0;
            sel      = $urandom_range(0, 1);
            in       = $urandom_range(0, 255);
            out0_rdy = $urandom_range(0, 2) != 0;
            out1_rdy = $urandom_range(0, 2) == 0;
            step();
        end
        reset = 1'b0; in_val = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux2_8b_buf.md
# demux2_8b_buf

Buffered 1-to-2 demultiplexer for 8-bit note/sample bytes: routes each byte accepted on a single input stream to output channel 0 or 1 according to `sel`, the inverse of the 2:1 byte mux in the music-player datapath. Each output channel has its own 2-entry FIFO, so the two consumers (e.g. tone generator and display/LED path) can stall independently without corrupting the other channel. Sits between the song-ROM sequencer and the per-channel playback logic.

## Interface
- `DEPTH`, 2, entries per output FIFO; fixed at 2 for this revision.
- `clk`  input  1  single system clock, all state updates on rising edge
- `reset`  input  1  synchronous, active-high reset
- `in`  input  8  input byte
- `in_val`  input  1  `in` and `sel` are valid this cycle
- `sel`  input  1  destination: 0 → channel 0, 1 → channel 1
- `in_rdy`  output  1  selected channel can accept a byte this cycle
- `out0`, `out1`  output  8  head byte of channel 0 / 1 FIFO
- `out0_val`, `out1_val`  output  1  channel FIFO non-empty
- `out0_rdy`, `out1_rdy`  input  1  consumer takes head this cycle
- `count0`, `count1`  output  2  occupancy of channel FIFO (0..2)

## Operation
- Input transfer when `in_val & in_rdy` at rising edge; byte enqueued into FIFO `sel`. Other FIFO unaffected.
- `in_rdy = !reset & !full[sel]`; depends only on `sel` and registered occupancy, never on `outN_rdy` (no combinational in→out ready path).
- Output transfer on channel N when `outN_val & outN_rdy` at rising edge; head dequeued.
- `outN_val = (countN != 0)`; `outN` = head entry when non-empty, 8'h00 when empty.
- Per-channel order preserved (FIFO); no ordering relation between channels.
- Each FIFO: write pointer, read pointer (1 bit each, wrap 1→0), 2-bit count. Count: +1 on enq only, −1 on deq only, unchanged on both.
- Simultaneous enq+deq on same channel:
  - count 0: enq only possible; deq blocked (`val` low).
  - count 1: both happen; count stays 1; new byte becomes head next cycle.
  - count 2: `in_rdy` low for that channel, so only deq; count → 1. Enq refused even though a slot frees this edge.
- `in_val` low: `sel` and `in` ignored; `in_rdy` still reflects `!full[sel]`.
- `outN_rdy` while `outN_val` low: ignored, no state change.

## Timing
- Reset (sync, any cycle incl. mid-stream): both FIFOs emptied, pointers 0, `count0/1 = 0`, `out0/1_val = 0`, `out0/1 = 8'h00`; `in_rdy = 0` while `reset` high, 1 in first cycle after. In-flight bytes discarded; no transfer occurs in a reset cycle.
- Latency: byte accepted at edge k appears on `outN` with `outN_val = 1` after edge k (visible cycle k+1) if FIFO was empty.
- Throughput: 1 byte/cycle per channel sustained when consumer holds `outN_rdy = 1`.
- All outputs except `in_rdy` are registered or pure functions of registered state; `in_rdy` is combinational from `sel`, `reset`.

## Structure
- Package `Demux_pkg`: `DEPTH = 2`, count width (2), typedef `byte_t` (logic [7:0]).
- One sub-module natural: `Fifo2_8b_RTL` (clk, reset, enq_val, enq_data, full, deq_rdy, deq_val, deq_data, count); instantiated twice. Top level is steering logic: `enq_val[N] = in_val & in_rdy & (sel == N)`.

## Test plan
- Reset: hold `reset` 2 cycles with `in_val=1` → `in_rdy=0`, all `val=0`, `out=0x00`, counts 0; release → `in_rdy=1`.
- Routing: send 0xA5 sel=0, 0x3C sel=1, consumers ready → `out0=0xA5` one cycle later, `out1=0x3C` next; no cross-channel leakage.
- Fill/backpressure: `out0_rdy=0`, send 0x11, 0x22, 0x33 to ch0 → count0=2, `in_rdy=0` with sel=0, 0x33 not accepted; sel=1 gives `in_rdy=1`; release `out0_rdy` → 0x11 then 0x22 in order.
- Simultaneous enq+deq at count 1 → count stays 1, next head is new byte; at count 2 with sel=0 → enq refused, count → 1.
- Wrap-around: stream 10 bytes 0x00..0x09 into ch1 with `out1_rdy` toggling 1/0 → output sequence 0x00..0x09, no loss/duplication.
- Reset mid-operation with both FIFOs at count 2 → next cycle both empty, stale bytes never reappear; random 200-cycle run vs. per-channel queue model (seeded `$urandom(t.seed)`).
